// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IFU, LSU) to one-slave memory arbiter with
// fixed LSU priority, one outstanding transaction and a WAIT watchdog.
//
// Ports:
//   clock, reset            sole clock (rising edge), sync active-high reset
//   ifu_reqValid/ifu_addr   fetch request, held until ifu_respValid
//   ifu_respValid/ifu_rdata one-cycle fetch response pulse and data
//   lsu_reqValid/lsu_addr/lsu_size/lsu_wen/lsu_wdata/lsu_wmask
//                           load/store request, held until lsu_respValid
//   lsu_respValid/lsu_rdata one-cycle load/store response pulse and data
//   mem_reqValid/mem_reqReady  request handshake towards memory
//   mem_addr/mem_size/mem_wen/mem_wdata/mem_wmask  latched request fields
//   mem_respValid/mem_rdata    memory response pulse and read data
//   bus_err                 one-cycle pulse with a watchdog error response
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        mem_reqValid,
    input  logic        mem_reqReady,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        owner_lsu;
    logic [7:0]  cnt;
    logic        finish;
    logic [31:0] resp_data;

    // A real response in the same cycle as the timeout wins.
    assign finish    = mem_respValid || (cnt == TMO);
    assign resp_data = mem_respValid ? mem_rdata : ERR_DATA;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (lsu_reqValid || ifu_reqValid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_reqReady) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (finish) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode only from registers, never from inputs.
    always_comb begin
        mem_reqValid  = (state == ISSUE);
        ifu_respValid = (state == RESP) && !owner_lsu;
        lsu_respValid = (state == RESP) && owner_lsu;
    end

    // Request latch, watchdog counter and response data
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_lsu <= 1'b0;
            cnt       <= 8'd0;
            bus_err   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_size  <= 2'd0;
            mem_wen   <= 1'b0;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
            ifu_rdata <= 32'd0;
            lsu_rdata <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lsu_reqValid) begin
                        owner_lsu <= 1'b1;
                        mem_addr  <= lsu_addr;
                        mem_size  <= lsu_size;
                        mem_wen   <= lsu_wen;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                    end else if (ifu_reqValid) begin
                        // Fetches are always full-word reads.
                        owner_lsu <= 1'b0;
                        mem_addr  <= ifu_addr;
                        mem_size  <= 2'b10;
                        mem_wen   <= 1'b0;
                        mem_wdata <= 32'd0;
                        mem_wmask <= 4'd0;
                    end
                end
                ISSUE: begin
                    if (mem_reqReady) begin
                        cnt <= 8'd0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (finish) begin
                        if (owner_lsu) begin
                            lsu_rdata <= resp_data;
                        end else begin
                            ifu_rdata <= resp_data;
                        end
                        bus_err <= !mem_respValid;
                    end
                end
                RESP: begin
                    bus_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a reactive
// memory model and a latency/priority reference computed from the rules.
module tb_mem_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic        mem_reqReady;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        bus_err;

    mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clock(clock),
        .reset(reset),
        .ifu_reqValid(ifu_reqValid),
        .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid),
        .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid),
        .lsu_addr(lsu_addr),
        .lsu_size(lsu_size),
        .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid),
        .lsu_rdata(lsu_rdata),
        .mem_reqValid(mem_reqValid),
        .mem_reqReady(mem_reqReady),
        .mem_addr(mem_addr),
        .mem_size(mem_size),
        .mem_wen(mem_wen),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_respValid(mem_respValid),
        .mem_rdata(mem_rdata),
        .bus_err(bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Observations gathered by run_txn
    int          obs_cyc;
    int          obs_req_cyc;
    logic [1:0]  obs_who;
    logic [31:0] obs_data;
    logic        obs_err;
    logic [70:0] obs_fields;
    bit          obs_unstable;
    bit          obs_extra;
    bit          obs_stray_err;
    bit          noise = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: cycles from the granting IDLE cycle to the response pulse.
    function automatic int exp_lat(input int rdy, input int rsp);
        return 3 + rdy + ((rsp > TO) ? TO : rsp);
    endfunction

    function automatic logic [70:0] lsu_fields();
        return {lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask};
    endfunction

    function automatic logic [70:0] ifu_fields();
        return {ifu_addr, 2'b10, 1'b0, 32'd0, 4'd0};
    endfunction

    // Runs one transaction from an IDLE cycle. The memory model accepts
    // after rdy stall cycles and answers rsp cycles after acceptance
    // (never, before the watchdog, if rsp > TO). Master fields are
    // scrambled after grant and restored at the response.
    task automatic run_txn(input int rdy, input int rsp,
                           input logic [31:0] data, input bit keep);
        int c;
        int issue_n;
        int acc;
        bit seen_req;
        bit done;
        logic [31:0] s_ifu_addr;
        logic [31:0] s_lsu_addr;
        logic [1:0]  s_lsu_size;
        logic        s_lsu_wen;
        logic [31:0] s_lsu_wdata;
        logic [3:0]  s_lsu_wmask;
        s_ifu_addr  = ifu_addr;
        s_lsu_addr  = lsu_addr;
        s_lsu_size  = lsu_size;
        s_lsu_wen   = lsu_wen;
        s_lsu_wdata = lsu_wdata;
        s_lsu_wmask = lsu_wmask;
        obs_cyc = -1;
        obs_req_cyc = -1;
        obs_who = 2'b00;
        obs_data = 32'd0;
        obs_err = 1'b0;
        obs_fields = '0;
        obs_unstable = 0;
        obs_extra = 0;
        obs_stray_err = 0;
        seen_req = 0;
        done = 0;
        issue_n = 0;
        acc = -1;
        c = 0;
        mem_reqReady = 1'b0;
        mem_respValid = 1'b0;
        while (!done && c < 80) begin
            step();
            c++;
            if (ifu_respValid || lsu_respValid) begin
                obs_cyc  = c;
                obs_who  = {lsu_respValid, ifu_respValid};
                obs_data = lsu_respValid ? lsu_rdata : ifu_rdata;
                obs_err  = bus_err;
                done = 1;
            end else if (bus_err) begin
                obs_stray_err = 1;
            end
            if (mem_reqValid) begin
                if (!seen_req) begin
                    obs_fields = {mem_addr, mem_size, mem_wen,
                                  mem_wdata, mem_wmask};
                    obs_req_cyc = c;
                    seen_req = 1;
                end else if ({mem_addr, mem_size, mem_wen, mem_wdata,
                              mem_wmask} !== obs_fields) begin
                    obs_unstable = 1;
                end
                issue_n++;
            end
            if (done) begin
                ifu_addr  = s_ifu_addr;
                lsu_addr  = s_lsu_addr;
                lsu_size  = s_lsu_size;
                lsu_wen   = s_lsu_wen;
                lsu_wdata = s_lsu_wdata;
                lsu_wmask = s_lsu_wmask;
                if (!keep) begin
                    if (obs_who[1]) lsu_reqValid = 1'b0;
                    if (obs_who[0]) ifu_reqValid = 1'b0;
                end
                mem_reqReady = 1'b0;
                mem_respValid = 1'b0;
            end else begin
                if (seen_req) begin
                    ifu_addr  = $urandom;
                    lsu_addr  = $urandom;
                    lsu_size  = 2'($urandom);
                    lsu_wen   = 1'($urandom);
                    lsu_wdata = $urandom;
                    lsu_wmask = 4'($urandom);
                end
                mem_reqReady = mem_reqValid && (issue_n > rdy);
                if (mem_reqReady) acc = c;
                if (acc >= 0 && c == acc + 1 + rsp) begin
                    mem_respValid = 1'b1;
                    mem_rdata = data;
                end else begin
                    mem_respValid = noise && mem_reqValid && !mem_reqReady;
                    mem_rdata = $urandom;
                end
            end
        end
        step();
        if (ifu_respValid || lsu_respValid || bus_err) obs_extra = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifu_reqValid = 1'b1;
        lsu_reqValid = 1'b1;
        ifu_addr = $urandom;
        lsu_addr = $urandom;
        lsu_wdata = $urandom;
        mem_reqReady = 1'b1;
        mem_respValid = 1'b1;
        mem_rdata = $urandom;
        step();
        step();
        total++;
        if ({mem_reqValid, ifu_respValid, lsu_respValid, bus_err} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000",
                     {mem_reqValid, ifu_respValid, lsu_respValid, bus_err});
        end
        total++;
        if ({mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask} !== 71'd0) begin
            bad++;
            $display("FAIL reset_fields got=%h want=0",
                     {mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask});
        end
        total++;
        if ({ifu_rdata, lsu_rdata} !== 64'd0) begin
            bad++;
            $display("FAIL reset_rdata got=%h want=0", {ifu_rdata, lsu_rdata});
        end
        ifu_reqValid = 1'b0;
        lsu_reqValid = 1'b0;
        mem_reqReady = 1'b0;
        mem_respValid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_ifu_read();
        logic [70:0] ef;
        ifu_reqValid = 1'b1;
        ifu_addr = 32'h8000_0000;
        lsu_wen = 1'b1;
        lsu_wdata = 32'h1234_5678;
        lsu_wmask = 4'hF;
        lsu_size = 2'b00;
        ef = ifu_fields();
        run_txn(0, 0, 32'h0000_0013, 0);
        total++;
        if (obs_req_cyc != 1) begin
            bad++;
            $display("FAIL ifu_req_cycle got=%0d want=1", obs_req_cyc);
        end
        total++;
        if (obs_cyc != 3 || obs_who !== 2'b01) begin
            bad++;
            $display("FAIL ifu_resp got=%0d/%b want=3/01", obs_cyc, obs_who);
        end
        total++;
        if (obs_data !== 32'h13 || obs_err !== 1'b0) begin
            bad++;
            $display("FAIL ifu_rdata got=%h/%b want=00000013/0", obs_data, obs_err);
        end
        total++;
        if (obs_fields !== ef) begin
            bad++;
            $display("FAIL ifu_fields got=%h want=%h", obs_fields, ef);
        end
        total++;
        if (obs_extra || obs_stray_err) begin
            bad++;
            $display("FAIL ifu_single_pulse got=%0d/%0d want=0/0",
                     obs_extra, obs_stray_err);
        end
    endtask

    task automatic test_priority();
        logic [70:0] ef;
        logic [31:0] d;
        ifu_reqValid = 1'b1;
        ifu_addr = $urandom;
        lsu_reqValid = 1'b1;
        lsu_addr = 32'h100;
        lsu_wen = 1'b1;
        lsu_wdata = 32'hAB00;
        lsu_wmask = 4'b0010;
        lsu_size = 2'b01;
        ef = lsu_fields();
        d = $urandom;
        run_txn(0, 0, d, 0);
        total++;
        if (obs_who !== 2'b10 || obs_cyc != 3) begin
            bad++;
            $display("FAIL prio_lsu_first got=%b/%0d want=10/3", obs_who, obs_cyc);
        end
        total++;
        if (obs_fields !== ef) begin
            bad++;
            $display("FAIL prio_lsu_fields got=%h want=%h", obs_fields, ef);
        end
        ef = ifu_fields();
        d = $urandom;
        run_txn(0, 1, d, 0);
        total++;
        if (obs_who !== 2'b01 || obs_cyc != exp_lat(0, 1) || obs_data !== d) begin
            bad++;
            $display("FAIL prio_ifu_next got=%b/%0d/%h want=01/%0d/%h",
                     obs_who, obs_cyc, obs_data, exp_lat(0, 1), d);
        end
        total++;
        if (obs_fields !== ef) begin
            bad++;
            $display("FAIL prio_ifu_fields got=%h want=%h", obs_fields, ef);
        end
    endtask

    task automatic test_backpressure();
        logic [70:0] ef;
        logic [31:0] d;
        lsu_reqValid = 1'b1;
        lsu_addr = $urandom;
        lsu_wen = 1'b0;
        lsu_size = 2'($urandom);
        lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom);
        ef = lsu_fields();
        d = $urandom;
        noise = 1;
        run_txn(5, 0, d, 0);
        noise = 0;
        total++;
        if (obs_cyc != exp_lat(5, 0) || obs_who !== 2'b10) begin
            bad++;
            $display("FAIL bp_latency got=%0d/%b want=%0d/10",
                     obs_cyc, obs_who, exp_lat(5, 0));
        end
        total++;
        if (obs_unstable || obs_fields !== ef) begin
            bad++;
            $display("FAIL bp_stable got=%0d/%h want=0/%h",
                     obs_unstable, obs_fields, ef);
        end
        total++;
        if (obs_data !== d || obs_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_data got=%h/%b want=%h/0", obs_data, obs_err, d);
        end
    endtask

    task automatic test_timeout();
        int r;
        logic [31:0] d;
        r = $urandom_range(0, 2);
        lsu_reqValid = 1'b1;
        lsu_addr = $urandom;
        lsu_wen = 1'b0;
        run_txn(r, 100, 32'h5555_5555, 0);
        total++;
        if (obs_cyc != exp_lat(r, 100) || obs_who !== 2'b10) begin
            bad++;
            $display("FAIL tmo_latency got=%0d/%b want=%0d/10",
                     obs_cyc, obs_who, exp_lat(r, 100));
        end
        total++;
        if (obs_data !== ERR || obs_err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_error got=%h/%b want=%h/1", obs_data, obs_err, ERR);
        end
        total++;
        if (obs_extra || obs_stray_err) begin
            bad++;
            $display("FAIL tmo_err_pulse got=%0d/%0d want=0/0",
                     obs_extra, obs_stray_err);
        end
        ifu_reqValid = 1'b1;
        ifu_addr = $urandom;
        d = $urandom;
        run_txn(0, 1, d, 0);
        total++;
        if (obs_cyc != exp_lat(0, 1) || obs_data !== d || obs_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_recover got=%0d/%h/%b want=%0d/%h/0",
                     obs_cyc, obs_data, obs_err, exp_lat(0, 1), d);
        end
    endtask

    task automatic test_tie();
        logic [31:0] d;
        d = $urandom;
        lsu_reqValid = 1'b1;
        lsu_addr = $urandom;
        run_txn(0, TO, d, 0);
        total++;
        if (obs_cyc != exp_lat(0, TO) || obs_data !== d || obs_err !== 1'b0) begin
            bad++;
            $display("FAIL tie_resp_wins got=%0d/%h/%b want=%0d/%h/0",
                     obs_cyc, obs_data, obs_err, exp_lat(0, TO), d);
        end
        ifu_reqValid = 1'b1;
        ifu_addr = $urandom;
        run_txn(1, TO + 1, d, 0);
        total++;
        if (obs_cyc != exp_lat(1, TO + 1) || obs_data !== ERR || obs_err !== 1'b1) begin
            bad++;
            $display("FAIL tie_one_late got=%0d/%h/%b want=%0d/%h/1",
                     obs_cyc, obs_data, obs_err, exp_lat(1, TO + 1), ERR);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        ifu_reqValid = 1'b1;
        ifu_addr = $urandom;
        d = $urandom;
        run_txn(0, 0, d, 1);
        total++;
        if (obs_cyc != 3 || obs_data !== d) begin
            bad++;
            $display("FAIL b2b_first got=%0d/%h want=3/%h", obs_cyc, obs_data, d);
        end
        d = $urandom;
        run_txn(0, 0, d, 0);
        total++;
        if (obs_cyc != 3 || obs_who !== 2'b01 || obs_data !== d) begin
            bad++;
            $display("FAIL b2b_second got=%0d/%b/%h want=3/01/%h",
                     obs_cyc, obs_who, obs_data, d);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        ifu_reqValid = 1'b1;
        ifu_addr = $urandom;
        step();
        mem_reqReady = 1'b1;
        step();
        mem_reqReady = 1'b0;
        reset = 1'b1;
        step();
        total++;
        if ({mem_reqValid, ifu_respValid, lsu_respValid, bus_err} !== 4'b0 ||
            {mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask} !== 71'd0 ||
            {ifu_rdata, lsu_rdata} !== 64'd0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b/%h/%h want=all zero",
                     {mem_reqValid, ifu_respValid, lsu_respValid, bus_err},
                     mem_addr, {ifu_rdata, lsu_rdata});
        end
        reset = 1'b0;
        ifu_reqValid = 1'b0;
        mem_respValid = 1'b1;
        mem_rdata = $urandom;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            mem_respValid = 1'b0;
            if (ifu_respValid || lsu_respValid || mem_reqValid || bus_err) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL midrst_late_resp got=activity want=none");
        end
    endtask

    task automatic test_random();
        bit pi;
        bit pl;
        int r;
        int s;
        logic [31:0] d;
        logic [70:0] ef;
        logic [1:0]  ew;
        pi = 0;
        pl = 0;
        for (int n = 0; n < 30; n++) begin
            if (!pi && $urandom_range(0, 1)) begin
                pi = 1;
                ifu_reqValid = 1'b1;
                ifu_addr = $urandom;
            end
            if (!pl && ($urandom_range(0, 1) || !pi)) begin
                pl = 1;
                lsu_reqValid = 1'b1;
                lsu_addr = $urandom;
                lsu_size = 2'($urandom);
                lsu_wen = 1'($urandom);
                lsu_wdata = $urandom;
                lsu_wmask = 4'($urandom);
            end
            ew = pl ? 2'b10 : 2'b01;
            ef = pl ? lsu_fields() : ifu_fields();
            r = $urandom_range(0, 3);
            s = $urandom_range(0, 6);
            d = $urandom;
            run_txn(r, s, d, 0);
            if (pl) pl = 0;
            else pi = 0;
            total++;
            if (obs_who !== ew || obs_cyc != exp_lat(r, s) || obs_fields !== ef) begin
                bad++;
                $display("FAIL rand_txn%0d got=%b/%0d/%h want=%b/%0d/%h",
                         n, obs_who, obs_cyc, obs_fields, ew, exp_lat(r, s), ef);
            end
            total++;
            if (obs_data !== ((s > TO) ? ERR : d) || obs_err !== (s > TO) ||
                obs_extra || obs_stray_err) begin
                bad++;
                $display("FAIL rand_resp%0d got=%h/%b want=%h/%b",
                         n, obs_data, obs_err, (s > TO) ? ERR : d, s > TO);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ifu_reqValid = 1'b0;
        ifu_addr = 32'd0;
        lsu_reqValid = 1'b0;
        lsu_addr = 32'd0;
        lsu_size = 2'd0;
        lsu_wen = 1'b0;
        lsu_wdata = 32'd0;
        lsu_wmask = 4'd0;
        mem_reqReady = 1'b0;
        mem_respValid = 1'b0;
        mem_rdata = 32'd0;
        test_reset();
        test_ifu_read();
        test_priority();
        test_backpressure();
        test_timeout();
        test_tie();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
